// File: rtl/hilo_acc_regs.sv
`default_nettype none
// ============================================================================
// Module   : hilo_acc_regs
// Purpose  : HI/LO special-register pair for the execute stage. Supports
//            HI-only, LO-only and combined writes, plus a two-cycle
//            multiply-accumulate path (MADD/MSUB) on the 2*DATA_W value
//            {HI,LO}, with a busy handshake toward the stall logic.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            op_valid  - an operation is presented this cycle
//            op[2:0]   - 0 NOP, 1 WR_HI, 2 WR_LO, 3 WR_BOTH, 4 MADD,
//                        5 MSUB, 6/7 reserved (no effect)
//            hi_in     - HI write data / upper half of accumulate operand
//            lo_in     - LO write data / lower half of accumulate operand
//            busy      - accumulate in flight, new ops are dropped
//            hi_out    - current HI value
//            lo_out    - current LO value
// Options  : HILO_BYPASS_EN - when defined, hi_out/lo_out forward accepted
//            write data in the same cycle, and show the accumulate result
//            during the busy cycle. Register timing is identical.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_acc_regs #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic              busy,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int ACC_W = 2 * DATA_W;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WR_HI   = 3'd1;
  localparam logic [2:0] OP_WR_LO   = 3'd2;
  localparam logic [2:0] OP_WR_BOTH = 3'd3;
  localparam logic [2:0] OP_MADD    = 3'd4;
  localparam logic [2:0] OP_MSUB    = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   w_hi_next;
  logic [DATA_W-1:0]   w_lo_next;
  logic [ACC_W-1:0]    r_operand;
  logic [ACC_W-1:0]    w_operand_next;
  logic                r_sub;
  logic                w_sub_next;
  logic [ACC_W-1:0]    w_acc_result;

  logic                w_accept;
  logic                w_wr_hi;
  logic                w_wr_lo;
  logic                w_start_acc;
  logic                w_start_sub;

  // Ops are accepted only when idle; busy comes straight from the state
  // register so there is no combinational path from op_valid to busy.
  assign busy     = (r_state == ST_ACC);
  assign w_accept = op_valid && (r_state == ST_IDLE);

  // Opcode decode, qualified by acceptance.
  always_comb begin
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    w_start_acc = 1'b0;
    w_start_sub = 1'b0;
    if (w_accept) begin
      case (op)
        OP_NOP:     ;
        OP_WR_HI:   w_wr_hi = 1'b1;
        OP_WR_LO:   w_wr_lo = 1'b1;
        OP_WR_BOTH: begin
          w_wr_hi = 1'b1;
          w_wr_lo = 1'b1;
        end
        OP_MADD:    w_start_acc = 1'b1;
        OP_MSUB: begin
          w_start_acc = 1'b1;
          w_start_sub = 1'b1;
        end
        default:    ;
      endcase
    end
  end

  // Full-width modulo arithmetic: the carry/borrow between LO and HI falls
  // out of treating {HI,LO} as one value; overflow simply wraps.
  assign w_acc_result = r_sub ? ({r_hi, r_lo} - r_operand)
                              : ({r_hi, r_lo} + r_operand);

  // Next-state and register-update logic.
  always_comb begin
    w_state_next   = r_state;
    w_hi_next      = r_hi;
    w_lo_next      = r_lo;
    w_operand_next = r_operand;
    w_sub_next     = r_sub;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_hi) begin
          w_hi_next = hi_in;
        end
        if (w_wr_lo) begin
          w_lo_next = lo_in;
        end
        if (w_start_acc) begin
          w_operand_next = {hi_in, lo_in};
          w_sub_next     = w_start_sub;
          w_state_next   = ST_ACC;
        end
      end
      ST_ACC: begin
        {w_hi_next, w_lo_next} = w_acc_result;
        w_state_next           = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Reset wins over any op in the same cycle and discards an in-flight
  // accumulate, so HI/LO end up zero rather than at the accumulate result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_operand <= '0;
      r_sub     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hi      <= w_hi_next;
      r_lo      <= w_lo_next;
      r_operand <= w_operand_next;
      r_sub     <= w_sub_next;
    end
  end

`ifdef HILO_BYPASS_EN
  // During the busy cycle the registers are about to take the accumulate
  // result, so that result is what gets presented. Otherwise accepted write
  // data is forwarded ahead of the register.
  always_comb begin
    hi_out = r_hi;
    lo_out = r_lo;
    if (busy) begin
      {hi_out, lo_out} = w_acc_result;
    end else begin
      if (w_wr_hi) begin
        hi_out = hi_in;
      end
      if (w_wr_lo) begin
        lo_out = lo_in;
      end
    end
  end
`else
  assign hi_out = r_hi;
  assign lo_out = r_lo;
`endif

endmodule
`default_nettype wire

// File: doc/hilo_acc_regs.md
Name: hilo_acc_regs

Overview:
- Parametrised HI/LO special-register pair for the execute stage, replacing the fixed single-write HI/LO register.
- Adds separate HI-only and LO-only writes (MTHI/MTLO), a combined write (MULT/DIV results), and a two-cycle multiply-accumulate path (MADD/MSUB) with a busy handshake toward the pipeline stall logic.
- Read ports feed the MFHI/MFLO datapath.

Parameters:
- DATA_W, 32, width of each of HI and LO; the accumulator spans 2*DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- op_valid  in  1  an operation is presented this cycle.
- op  in  3  0 NOP, 1 WR_HI, 2 WR_LO, 3 WR_BOTH, 4 MADD, 5 MSUB; 6 and 7 reserved, treated as NOP.
- hi_in  in  DATA_W  write data for HI, or upper half of the accumulate operand.
- lo_in  in  DATA_W  write data for LO, or lower half of the accumulate operand.
- busy  out  1  an accumulate is in flight; new ops are not accepted.
- hi_out  out  DATA_W  current HI value.
- lo_out  out  DATA_W  current LO value.

Behaviour:
- Reset state: on rst at a clock edge, HI=0, LO=0, accumulate stage cleared, busy=0. This takes priority over any op in the same cycle.
- Reset mid-accumulate: rst discards the in-flight operand; HI/LO become 0, not the accumulate result.
- Accept condition: an op is accepted when op_valid=1 and busy=0.
  - While busy=1, op_valid is ignored and the op is dropped with no side effects.
  - The stall unit must hold the instruction until busy=0.
- WR_HI: HI <= hi_in at the edge; LO unchanged.
- WR_LO: LO <= lo_in; HI unchanged.
- WR_BOTH: HI <= hi_in and LO <= lo_in in the same edge.
- Write latency: 1 cycle. Without bypass, outputs show the new value in the cycle after the edge.
- MADD / MSUB, two-stage:
  - Edge A (accept): latch operand {hi_in,lo_in} and the add/sub flag into stage registers; busy goes 1.
  - Cycle after A: busy=1; hi_out/lo_out still show the old value.
  - Edge B: {HI,LO} <= {HI,LO} + operand (MADD) or {HI,LO} - operand (MSUB); busy returns to 0.
  - Accumulate latency 2 cycles; throughput one accumulate per 2 cycles.
  - Back-to-back: a second op can be accepted in the cycle after edge B.
- Arithmetic: unsigned 2*DATA_W, modulo 2^(2*DATA_W).
  - Carry from LO into HI propagates.
  - Overflow and borrow wrap silently; no flags.
- NOP and reserved ops: no state change, busy unaffected.
- busy depends only on registered state; it has no combinational path from op_valid.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: hi_out/lo_out forward combinationally from an accepted write in the same cycle.
  - WR_HI forwards hi_in on hi_out.
  - WR_LO forwards lo_in on lo_out.
  - WR_BOTH forwards both.
  - During the busy cycle of an accumulate, the outputs present the accumulate result (the result computed at edge B).
  - Register update timing is unchanged.
- Not defined: hi_out/lo_out are pure register outputs, and the write-to-read latency is 1 cycle.

Test Plan:
- Reset: assert rst with op=WR_BOTH, hi_in=0xDEADBEEF, lo_in=0x12345678 -> after the edge hi_out=0, lo_out=0, busy=0.
- Split writes: WR_HI 0xAAAA0000, next cycle WR_LO 0x0000BBBB -> hi_out=0xAAAA0000, lo_out=0x0000BBBB; each write leaves the other half unchanged.
- MADD carry: HI=0, LO=0xFFFFFFFF, MADD operand {0,1} -> busy=1 for exactly one cycle, then HI=1, LO=0, busy=0.
- MSUB wrap: HI=0, LO=0, MSUB operand {0,1} -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- Busy drop and reset mid-op:
  - MADD is accepted; in the busy cycle present WR_BOTH {5,5} -> the write is ignored; the final value is the accumulate result only.
  - Separately, assert rst in the busy cycle -> HI=LO=0 and busy=0 on the next cycle.
- HILO_BYPASS_EN build: WR_LO 0x77 -> lo_out=0x77 in the same cycle. Without the macro, lo_out=0x77 only after the edge.
